// File: rtl/fetch_pkg.sv
// Shared types and constants for the SIMPLE-core instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] OP_HI   = 2'b11;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:14] == OP_HI) && (word[7:4] == OP3_HLT);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus and command handshake between fetch and ControlUnit.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] command;
  logic              cmd_valid;
  logic              cmd_done;
  logic              pcl;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] pc;

  modport master (
    output mem_addr, mem_rd, command, cmd_valid, pc,
    input  mem_rdata, mem_ready, cmd_done, pcl, pc_target
  );

  modport slave (
    input  mem_addr, mem_rd, command, cmd_valid, pc,
    output mem_rdata, mem_ready, cmd_done, pcl, pc_target
  );
endinterface

// File: rtl/exec_edge.sv
// Registers the EXEC button level and emits a one-cycle pulse on each rising edge.
module exec_edge (
  input  logic clock_i,
  input  logic reset_i,
  input  logic exec_i,
  output logic edge_o
);
  logic exec_q;

  // Previous EXEC level.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      exec_q <= 1'b0;
    end else begin
      exec_q <= exec_i;
    end
  end

  assign edge_o = exec_i & ~exec_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake, command issue and run/halt control.
// Optional one-entry prefetch buffer enabled with FETCH_PREFETCH_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic         clock,
  input  logic         RESET,
  input  logic         EXEC,
  fetch_unit_if.master bus,
  output logic         running
);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] command_q, command_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              stop_q, stop_d;
  logic              running_q, running_d;
  logic              edge_s;
  logic              ready_s;
`ifdef FETCH_PREFETCH_EN
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic              pf_valid_q, pf_valid_d;
  logic              pf_hit_s;
  logic [DATA_W-1:0] pf_word_s;
  logic              pending_s;
`endif

  exec_edge u_exec_edge (
    .clock_i (clock),
    .reset_i (RESET),
    .exec_i  (EXEC),
    .edge_o  (edge_s)
  );

  // A stray mem_ready with no request in flight (e.g. after RESET) is ignored.
  assign ready_s = mem_rd_q & bus.mem_ready;
`ifdef FETCH_PREFETCH_EN
  assign pf_hit_s  = pf_valid_q | ready_s;
  assign pf_word_s = pf_valid_q ? pf_data_q : bus.mem_rdata;
  assign pending_s = mem_rd_q & ~bus.mem_ready;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    command_d = command_q;
    stop_d    = stop_q;
`ifdef FETCH_PREFETCH_EN
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
`endif
    case (state_q)
      HALT: begin
        if (edge_s) state_d = FETCH;
        else        state_d = HALT;
      end
      FETCH: begin
        if (edge_s) stop_d = 1'b1;
        if (ready_s) begin
          command_d = bus.mem_rdata;
          pc_d      = pc_q + PC_ONE;
          state_d   = is_hlt(bus.mem_rdata) ? HALT : ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (edge_s) stop_d = 1'b1;
`ifdef FETCH_PREFETCH_EN
        if (bus.cmd_done) begin
          if (bus.pcl || stop_q || edge_s) begin
            if (bus.pcl) pc_d = bus.pc_target;
            pf_valid_d = 1'b0;
            // An unfinished read must complete before the bus can be reused.
            if (pending_s)            state_d = DRAIN;
            else if (stop_q || edge_s) state_d = HALT;
            else                       state_d = FETCH;
          end else if (pf_hit_s) begin
            command_d  = pf_word_s;
            pc_d       = pc_q + PC_ONE;
            pf_valid_d = 1'b0;
            state_d    = is_hlt(pf_word_s) ? HALT : ISSUE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          if (ready_s) begin
            pf_data_d  = bus.mem_rdata;
            pf_valid_d = 1'b1;
          end
          state_d = ISSUE;
        end
`else
        if (bus.cmd_done) begin
          if (bus.pcl) pc_d = bus.pc_target;
          else         pc_d = pc_q;
          state_d = (stop_q || edge_s) ? HALT : FETCH;
        end else begin
          state_d = ISSUE;
        end
`endif
      end
`ifdef FETCH_PREFETCH_EN
      DRAIN: begin
        if (edge_s) stop_d = 1'b1;
        if (ready_s) state_d = (stop_q || edge_s) ? HALT : FETCH;
        else         state_d = DRAIN;
      end
`endif
      default: state_d = HALT;
    endcase

    if (state_d == HALT) stop_d = 1'b0;

    mem_rd_d    = (state_d == FETCH) || (state_d == DRAIN);
`ifdef FETCH_PREFETCH_EN
    mem_rd_d    = mem_rd_d || ((state_d == ISSUE) && !pf_valid_d);
`endif
    // While draining, the address of the abandoned read is held stable.
    mem_addr_d  = (state_d == DRAIN) ? mem_addr_q : pc_d;
    cmd_valid_d = (state_d == ISSUE);
    running_d   = (state_d != HALT);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (RESET) begin
      state_q     <= HALT;
      pc_q        <= RESET_PC;
      mem_addr_q  <= RESET_PC;
      mem_rd_q    <= 1'b0;
      command_q   <= {DATA_W{1'b0}};
      cmd_valid_q <= 1'b0;
      stop_q      <= 1'b0;
      running_q   <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_data_q   <= {DATA_W{1'b0}};
      pf_valid_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      command_q   <= command_d;
      cmd_valid_q <= cmd_valid_d;
      stop_q      <= stop_d;
      running_q   <= running_d;
`ifdef FETCH_PREFETCH_EN
      pf_data_q   <= pf_data_d;
      pf_valid_q  <= pf_valid_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.command   = command_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.pc        = pc_q;
  assign running       = running_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs, memory model with wait states,
// and a monitor that checks every retired command against the expected queue.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, exec, cmd_done, pcl;
  logic [15:0] pc_target;
  logic        model_ready, inject_ready;
  logic [15:0] model_data, inject_data;
  logic        running;

  logic [15:0] mem [0:65535];
  int          wait_cfg = 1;
  int          wait_cnt;
  int          checks = 0;
  int          passed = 0;

  typedef struct packed {
    logic [15:0] cmd;
    logic [15:0] pc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  assign bus.mem_ready = model_ready | inject_ready;
  assign bus.mem_rdata = inject_ready ? inject_data : model_data;
  assign bus.cmd_done  = cmd_done;
  assign bus.pcl       = pcl;
  assign bus.pc_target = pc_target;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clock   (clk),
    .RESET   (rst),
    .EXEC    (exec),
    .bus     (bus.master),
    .running (running)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_cmd(input logic [15:0] c, input logic [15:0] p);
    sb_q.push_back({c, p});
  endtask

  task automatic exec_pulse();
    tick();
    exec = 1'b1;
    tick();
    exec = 1'b0;
  endtask

  task automatic retire(input logic do_pcl, input logic [15:0] tgt, input logic with_exec);
    tick();
    cmd_done  = 1'b1;
    pcl       = do_pcl;
    pc_target = tgt;
    exec      = with_exec;
    tick();
    cmd_done = 1'b0;
    pcl      = 1'b0;
    exec     = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_valid !== 1'b1) begin
      checks++;
      $display("FAIL %s: cmd_valid still low after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (running !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (running !== 1'b0) begin
      checks++;
      $display("FAIL %s: running still high after %0d cycles, expected 0", name, n);
    end
  endtask

  // Instruction memory: answers mem_rd after wait_cfg wait cycles.
  initial begin
    model_ready = 1'b0;
    model_data  = 16'h0000;
    wait_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_rd === 1'b1) begin
        if (wait_cnt >= wait_cfg) begin
          model_ready = 1'b1;
          model_data  = mem[bus.mem_addr];
          wait_cnt    = 0;
        end else begin
          model_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        model_ready = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Monitor: every retired command must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1 && cmd_done === 1'b1) begin : retire_chk
        exp_t e;
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL retire_unexpected: got command 0x%0h, expected none", bus.command);
        end else begin
          e = sb_q.pop_front();
          check("retire_cmd", bus.command, e.cmd);
          check("retire_pc", bus.pc, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; exec = 1'b0; cmd_done = 1'b0; pcl = 1'b0; pc_target = 16'h0000;
    inject_ready = 1'b0; inject_data = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'hCF0F;
    mem[16'h0001] = 16'h1111;
    mem[16'h0002] = 16'h2222;
    mem[16'h0003] = 16'hC0F0;
    mem[16'h0004] = 16'h4444;
    mem[16'h0040] = 16'h4040;
    mem[16'h0041] = 16'h5555;
    mem[16'hFFFF] = 16'h6666;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_running", {15'd0, running}, 16'h0000);
    check("rst_cmd_valid", {15'd0, bus.cmd_valid}, 16'h0000);
    check("rst_mem_rd", {15'd0, bus.mem_rd}, 16'h0000);
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_command", bus.command, 16'h0000);

`ifdef FETCH_PREFETCH_EN
    wait_cfg = 0;
    mem[16'h0000] = 16'h3101;
    mem[16'h0001] = 16'h3202;
    mem[16'h0002] = 16'h7777;
    expect_cmd(16'h3101, 16'h0001);
    expect_cmd(16'h3202, 16'h0002);
    exec_pulse();
    wait_valid("pf_first_issue");
    wait_cfg = 3;
    retire(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    check("pf_zero_bubble_valid", {15'd0, bus.cmd_valid}, 16'h0001);
    check("pf_zero_bubble_cmd", bus.command, 16'h3202);
    expect_cmd(16'h4040, 16'h0041);
    retire(1'b1, 16'h0040, 1'b0);
    @(negedge clk);
    check("pf_drain_rd", {15'd0, bus.mem_rd}, 16'h0001);
    check("pf_drain_addr", bus.mem_addr, 16'h0002);
    wait_valid("pf_after_drain");
    retire(1'b0, 16'h0000, 1'b1);
    wait_halt("pf_stop");
    check("pf_stop_valid", {15'd0, bus.cmd_valid}, 16'h0000);
`else
    wait_cfg = 1;
    expect_cmd(16'hCF0F, 16'h0001);
    exec_pulse();
    wait_valid("first_issue");
    retire(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    check("next_fetch_rd", {15'd0, bus.mem_rd}, 16'h0001);
    check("next_fetch_addr", bus.mem_addr, 16'h0001);

    expect_cmd(16'h1111, 16'h0002);
    wait_valid("issue_1");
    retire(1'b0, 16'h0000, 1'b0);
    expect_cmd(16'h2222, 16'h0003);
    wait_valid("issue_2");
    retire(1'b0, 16'h0000, 1'b0);
    wait_halt("hlt_halt");
    check("hlt_cmd_valid", {15'd0, bus.cmd_valid}, 16'h0000);
    check("hlt_pc", bus.pc, 16'h0004);

    expect_cmd(16'h4444, 16'h0005);
    exec_pulse();
    @(negedge clk);
    check("restart_rd", {15'd0, bus.mem_rd}, 16'h0001);
    check("restart_addr", bus.mem_addr, 16'h0004);
    wait_valid("issue_4");
    tick();
    pcl = 1'b1;
    pc_target = 16'h0099;
    tick();
    pcl = 1'b0;
    @(negedge clk);
    check("pcl_no_done_pc", bus.pc, 16'h0005);
    check("pcl_no_done_valid", {15'd0, bus.cmd_valid}, 16'h0001);

    retire(1'b1, 16'h0040, 1'b0);
    @(negedge clk);
    check("pcl_addr", bus.mem_addr, 16'h0040);
    check("pcl_rd", {15'd0, bus.mem_rd}, 16'h0001);

    expect_cmd(16'h4040, 16'h0041);
    wait_valid("issue_40");
    retire(1'b1, 16'hFFFF, 1'b0);
    @(negedge clk);
    check("jump_ffff_addr", bus.mem_addr, 16'hFFFF);

    expect_cmd(16'h6666, 16'h0000);
    wait_valid("issue_ffff");
    retire(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    check("wrap_next_addr", bus.mem_addr, 16'h0000);
    check("wrap_next_rd", {15'd0, bus.mem_rd}, 16'h0001);

    expect_cmd(16'hCF0F, 16'h0001);
    exec_pulse();
    wait_valid("stop_in_fetch_issue");
    retire(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    check("stop_running", {15'd0, running}, 16'h0000);
    check("stop_mem_rd", {15'd0, bus.mem_rd}, 16'h0000);
    check("stop_cmd_valid", {15'd0, bus.cmd_valid}, 16'h0000);

    expect_cmd(16'h1111, 16'h0002);
    exec_pulse();
    wait_valid("stop_with_done_issue");
    retire(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    check("edge_with_done_running", {15'd0, running}, 16'h0000);
    check("edge_with_done_pc", bus.pc, 16'h0002);

    wait_cfg = 6;
    exec_pulse();
    @(negedge clk);
    check("pre_reset_rd", {15'd0, bus.mem_rd}, 16'h0001);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inject_data  = 16'h1234;
    inject_ready = 1'b1;
    tick();
    tick();
    inject_ready = 1'b0;
    @(negedge clk);
    check("midread_rst_running", {15'd0, running}, 16'h0000);
    check("midread_rst_command", bus.command, 16'h0000);
    check("midread_rst_pc", bus.pc, 16'h0000);
    check("midread_rst_mem_rd", {15'd0, bus.mem_rd}, 16'h0000);
    check("midread_rst_valid", {15'd0, bus.cmd_valid}, 16'h0000);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of ControlUnit in the 16-bit SIMPLE core.
- Owns the program counter and fetches 16-bit words from instruction memory over a ready handshake.
- Presents the fetched word as `command` with a valid/done handshake, accepts PC loads (`pcl`) at instruction boundaries, and implements run/halt control from the EXEC button and the HLT instruction.

Parameters:
- ADDR_W, 16, width of the PC and the memory address.
- DATA_W, 16, instruction width; must equal 16.
- RESET_PC, 0, PC value loaded by RESET.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- EXEC  in  1  run/stop button level; each 0->1 transition is one toggle request.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_rd  out  1  read request; held high until mem_ready.
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  read completes this cycle.
- command  out  DATA_W  instruction register presented to ControlUnit.
- cmd_valid  out  1  command holds a live instruction.
- cmd_done  in  1  ControlUnit finished the current command; sampled only while cmd_valid=1.
- pcl  in  1  load PC from pc_target; qualified by cmd_done.
- pc_target  in  ADDR_W  branch/jump target.
- pc  out  ADDR_W  current PC, i.e. address of the issued command + 1, used for PC-relative branches.
- running  out  1  1 in every state except HALT.

Behaviour:
- Reset values: PC=RESET_PC, state=HALT, command=0, cmd_valid=0, mem_rd=0, mem_addr=RESET_PC, running=0, stop_req=0, EXEC edge register=0.
- RESET asserted in any state, including mid-read, aborts the operation. mem_rd is 0 the next cycle, and any later mem_ready is ignored.
- EXEC edge: the EXEC level is registered; edge = EXEC & ~EXEC_q.
- States: HALT, FETCH, ISSUE.
- HALT
  - mem_rd=0, cmd_valid=0.
  - On an edge: go to FETCH.
- FETCH
  - mem_rd=1, mem_addr=PC.
  - On mem_ready: command<=mem_rdata and PC<=PC+1, wrapping modulo 2^ADDR_W (0xFFFF->0x0000).
  - If mem_rdata is HLT (bits[15:14]=11 and bits[7:4]=1111), go to HALT with cmd_valid=0. HLT is never issued, and PC already points past it.
  - Otherwise go to ISSUE.
- ISSUE
  - cmd_valid=1, mem_rd=0.
  - On cmd_done: if pcl, PC<=pc_target; otherwise PC is unchanged. Then go to HALT if stop_req, else FETCH. cmd_valid falls the next cycle.
  - pcl without cmd_done, or pcl outside ISSUE, is ignored.
- stop_req
  - Set by an edge in FETCH or ISSUE.
  - Cleared on entering HALT.
  - An edge in the same cycle as cmd_done still stops at that boundary.
- Latency: HALT edge -> mem_rd next cycle. mem_ready in cycle N -> cmd_valid in cycle N+1. Back-to-back throughput is one instruction per 2 + memory-wait cycles.
- command holds its value while in HALT and FETCH; it changes only on a captured read.

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- With the macro:
  - A one-entry prefetch buffer (pf_data, pf_valid).
  - In ISSUE with pf_valid=0, the block reads PC (mem_rd=1) and fills the buffer on mem_ready.
  - On cmd_done without pcl, without stop_req, and with pf_valid=1:
    - command<=pf_data, PC<=PC+1, pf_valid<=0.
    - cmd_valid stays 1, giving zero bubble.
    - HLT in the buffer goes to HALT instead.
  - On cmd_done with pcl while a read is outstanding: enter DRAIN, hold mem_rd until mem_ready, discard the data, then go to FETCH at pc_target.
  - pcl or stop also clears pf_valid.
- Without the macro: no memory access in ISSUE, no DRAIN state, buffer logic absent.

Decomposition:
- Package fetch_pkg holds:
  - state enum (HALT, FETCH, ISSUE, DRAIN);
  - HLT match constants (OP_HI=2'b11, OP3_HLT=4'b1111);
  - default ADDR_W/DATA_W.
- One sub-module: exec_edge, a registered EXEC level with 1-cycle rising-edge pulse output, reset to 0.

Test Plan:
- Reset, then EXEC edge; memory returns 0xCF0F at addr 0 with a 1-cycle wait -> command=0xCF0F, cmd_valid=1, pc=1; after cmd_done -> mem_addr=1.
- Word at addr 3 = 0xC0F0 (HLT) -> running=0, cmd_valid never 1 for it, pc=4; next EXEC edge fetches addr 4.
- In ISSUE: cmd_done=1, pcl=1, pc_target=0x0040 -> next mem_addr=0x0040; pcl=1 without cmd_done -> PC unchanged.
- PC=0xFFFF: fetch completes -> pc=0x0000 and the next fetch address is 0x0000.
- EXEC edge during FETCH -> instruction still issued; on cmd_done -> HALT, mem_rd=0. RESET during FETCH with mem_ready arriving later -> state HALT, command=0, pc=RESET_PC.
- FETCH_PREFETCH_EN:
  - Sequential words 0x3101, 0x3202 -> second command appears the cycle after cmd_done, cmd_valid continuously 1.
  - pcl with a read outstanding -> stale data dropped, fetch from pc_target.
